// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter with one-byte holding register
//
// Takes bytes over a valid/ready handshake and sends each one as a serial frame.
// A frame is a start bit, then 8 data bits MSB first, then an optional odd-parity
// bit, then a stop bit. While a frame is on the line, one more byte can wait in
// the holding register. That byte starts right after the stop bit, with no idle gap.
//
// Build option:
//   TX_PARITY_EN  defined   -> frame carries an odd-parity bit (11 bits)
//                 undefined -> no parity bit (10 bits)
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   baudRate    bit rate, sampled when a frame is loaded (0 is treated as 1)
//   DATA_IN     byte to transmit
//   data_valid  DATA_IN valid this cycle
//   ready       holding register empty; a byte is accepted when data_valid & ready
//   Tx          serial line output, idle high, registered
//   busy        frame in progress

module uart_transmitter #(
    parameter int CLK_HZ = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] baudRate,
    input  logic [7:0]  DATA_IN,
    input  logic        data_valid,
    output logic        ready,
    output logic        Tx,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [31:0] CLK_HZ_W = 32'(CLK_HZ);

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] limit_q, limit_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
`ifdef TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic [19:0] baud_eff;
    logic [31:0] quot;
    logic [19:0] limit_new;
    logic        period_end;
    logic        load;
    logic        accept;

    // limit_q holds P-1, where P = CLK_HZ/baud + 1 clocks per bit. The period
    // counter runs 0..limit_q. If the quotient does not fit in 20 bits, it
    // saturates instead of wrapping.
    assign baud_eff   = (baudRate == 20'd0) ? 20'd1 : baudRate;
    assign quot       = CLK_HZ_W / {12'd0, baud_eff};
    assign limit_new  = (quot[31:20] != 12'd0) ? 20'hFFFFF : quot[19:0];
    assign period_end = (cnt_q == limit_q);

    // ready comes only from a flop, so it never depends on data_valid in the
    // same cycle.
    assign ready  = ~hold_full_q;
    assign accept = data_valid & ready;
    assign Tx     = tx_q;
    assign busy   = busy_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        limit_d     = limit_q;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        load        = 1'b0;
`ifdef TX_PARITY_EN
        parity_d    = parity_q;
`endif

        if (state_q != S_IDLE) begin
            cnt_d = period_end ? 20'd0 : cnt_q + 20'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (period_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (period_end) begin
                    if (bit_cnt_q == 4'd0) begin
`ifdef TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (period_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (period_end) begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load always empties the holding register. An accept needs it to be
        // empty already, so the two can never happen on the same edge.
        if (load) begin
            state_d     = S_START;
            shift_d     = hold_q;
            bit_cnt_d   = 4'd7;
            cnt_d       = 20'd0;
            limit_d     = limit_new;
            hold_full_d = 1'b0;
`ifdef TX_PARITY_EN
            parity_d    = ~^hold_q;
`endif
        end

        if (accept) begin
            hold_d      = DATA_IN;
            hold_full_d = 1'b1;
        end

        // Tx is registered. It shows the bit of the state being entered, so the
        // line changes on the same edge as the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[7];
`ifdef TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 4'd0;
            cnt_q       <= 20'd0;
            limit_q     <= 20'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            limit_q     <= limit_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
`ifdef TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter

module tb_uart_transmitter;

    localparam int CLK_HZ = 5;
`ifdef TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif

    typedef logic [7:0] bq_t[$];
    typedef int         iq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] baudRate = 20'd1;
    logic [7:0]  DATA_IN = 8'd0;
    logic        data_valid = 1'b0;
    logic        ready;
    logic        Tx;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic tx_tr[$];
    logic busy_tr[$];
    logic rdy_tr[$];
    logic exp_tx[$];
    logic exp_busy[$];
    int   n_acc;

    uart_transmitter #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .baudRate(baudRate), .DATA_IN(DATA_IN),
        .data_valid(data_valid), .ready(ready), .Tx(Tx), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int period_of(input int baud);
        int b;
        b = (baud == 0) ? 1 : baud;
        return CLK_HZ / b + 1;
    endfunction

    function automatic int first_diff(input logic a[$], input logic b[$]);
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic int count_ones(input logic a[$]);
        int n = 0;
        foreach (a[i]) if (a[i] === 1'b1) n++;
        return n;
    endfunction

    // Builds the expected line and busy trace for a stream of bytes sent back to
    // back. Sample 0 is taken just after the first byte is accepted.
    task automatic build_expected(input bq_t bytes, input iq_t per);
        logic bits[$];
        exp_tx.delete();
        exp_busy.delete();
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b0);
        foreach (bytes[j]) begin
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 7; i >= 0; i--) bits.push_back(bytes[j][i]);
`ifdef TX_PARITY_EN
            bits.push_back(~^bytes[j]);
`endif
            bits.push_back(1'b1);
            foreach (bits[k]) begin
                for (int c = 0; c < per[j]; c++) begin
                    exp_tx.push_back(bits[k]);
                    exp_busy.push_back(1'b1);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endtask

    // Offers bytes with data_valid held high and records the outputs once per
    // cycle, for as many cycles as the expected trace is long.
    task automatic run_frames(input bq_t bytes, input int baud, input int chg_at,
                              input int baud2);
        int   idx;
        logic pend;
        int   n;
        n = exp_tx.size();
        tx_tr.delete();
        busy_tr.delete();
        rdy_tr.delete();
        @(negedge clk);
        baudRate   = 20'(baud);
        DATA_IN    = bytes[0];
        data_valid = 1'b1;
        idx        = 0;
        pend       = ready;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tx_tr.push_back(Tx);
            busy_tr.push_back(busy);
            rdy_tr.push_back(ready);
            if (pend) begin
                idx++;
                if (idx < bytes.size()) DATA_IN = bytes[idx];
                else data_valid = 1'b0;
            end
            if (c == chg_at) baudRate = 20'(baud2);
            pend = data_valid && ready;
        end
        data_valid = 1'b0;
        n_acc = idx;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (Tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", Tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", ready); end
    endtask

    task automatic test_a5();
        logic [10:0] pat;
        int err;
        int d;
`ifdef TX_PARITY_EN
        pat = 11'b01010010111;
`else
        pat = {10'b0101001011, 1'b0};
`endif
        build_expected('{8'hA5}, '{6});
        run_frames('{8'hA5}, 1, -1, 1);
        err = -1;
        for (int k = 0; k < FBITS; k++)
            for (int c = 0; c < 6; c++)
                if (err < 0 && tx_tr[1 + k * 6 + c] !== pat[10 - k]) err = k;
        total++;
        if (err >= 0) begin
            bad++;
            $display("FAIL a5_pattern: bit %0d got %b expected %b", err, tx_tr[1 + err * 6], pat[10 - err]);
        end
        d = first_diff(tx_tr, exp_tx);
        total++; if (d !== -1) begin bad++; $display("FAIL a5_trace: first difference at sample %0d", d); end
        total++;
        if (count_ones(busy_tr) !== FBITS * 6) begin
            bad++;
            $display("FAIL a5_busy_len: got %0d expected %0d", count_ones(busy_tr), FBITS * 6);
        end
        d = first_diff(busy_tr, exp_busy);
        total++; if (d !== -1) begin bad++; $display("FAIL a5_busy_trace: first difference at sample %0d", d); end
        total++; if (rdy_tr[0] !== 1'b0) begin bad++; $display("FAIL a5_ready_low: got %b expected 0", rdy_tr[0]); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL a5_ready_end: got %b expected 1", ready); end
    endtask

    task automatic test_parity_values();
        logic [7:0] vals[3];
        logic       pexp[3];
        int d;
        vals[0] = 8'h00; pexp[0] = 1'b1;
        vals[1] = 8'hFF; pexp[1] = 1'b1;
        vals[2] = 8'h01; pexp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            build_expected('{vals[i]}, '{6});
            run_frames('{vals[i]}, 1, -1, 1);
            d = first_diff(tx_tr, exp_tx);
            total++;
            if (d !== -1) begin bad++; $display("FAIL parity_trace_%0h: first difference at sample %0d", vals[i], d); end
`ifdef TX_PARITY_EN
            total++;
            if (tx_tr[1 + 9 * 6] !== pexp[i]) begin
                bad++;
                $display("FAIL parity_bit_%0h: got %b expected %b", vals[i], tx_tr[1 + 9 * 6], pexp[i]);
            end
`else
            total++;
            if (tx_tr[1 + 9 * 6] !== 1'b1) begin
                bad++;
                $display("FAIL stop_bit_%0h: got %b expected 1 (parity %b unused)", vals[i], tx_tr[1 + 9 * 6], pexp[i]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int d;
        int lows;
        int fp;
        fp = FBITS * 6;
        build_expected('{8'h3C, 8'hC3}, '{6, 6});
        run_frames('{8'h3C, 8'hC3}, 1, -1, 1);
        d = first_diff(tx_tr, exp_tx);
        total++; if (d !== -1) begin bad++; $display("FAIL b2b_trace: first difference at sample %0d", d); end
        total++;
        if (count_ones(busy_tr) !== 2 * fp) begin
            bad++;
            $display("FAIL b2b_busy_len: got %0d expected %0d", count_ones(busy_tr), 2 * fp);
        end
        total++; if (n_acc !== 2) begin bad++; $display("FAIL b2b_accepts: got %0d expected 2", n_acc); end
        lows = 0;
        for (int c = 2; c <= fp; c++) if (rdy_tr[c] === 1'b0) lows++;
        total++;
        if (lows !== fp - 1) begin bad++; $display("FAIL b2b_ready_held: low samples %0d expected %0d", lows, fp - 1); end
        total++;
        if (rdy_tr[1 + fp] !== 1'b1) begin bad++; $display("FAIL b2b_ready_reload: got %b expected 1", rdy_tr[1 + fp]); end
    endtask

    task automatic test_baud();
        int d;
        build_expected('{8'hA5}, '{period_of(0)});
        run_frames('{8'hA5}, 0, -1, 0);
        d = first_diff(tx_tr, exp_tx);
        total++; if (d !== -1) begin bad++; $display("FAIL baud_zero: first difference at sample %0d", d); end
        // The rate changes partway through frame 1, so only frame 2 should use it.
        build_expected('{8'h3C, 8'hC3}, '{period_of(1), period_of(3)});
        run_frames('{8'h3C, 8'hC3}, 1, 10, 3);
        d = first_diff(tx_tr, exp_tx);
        total++; if (d !== -1) begin bad++; $display("FAIL baud_change: first difference at sample %0d", d); end
    endtask

    task automatic test_random();
        bq_t bytes;
        iq_t per;
        int  n;
        int  baud;
        int  d;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 3);
            baud = $urandom_range(0, 6);
            bytes.delete();
            per.delete();
            for (int i = 0; i < n; i++) begin
                bytes.push_back(8'($urandom));
                per.push_back(period_of(baud));
            end
            build_expected(bytes, per);
            run_frames(bytes, baud, -1, baud);
            d = first_diff(tx_tr, exp_tx);
            total++; if (d !== -1) begin bad++; $display("FAIL rand%0d_trace: baud %0d first difference at %0d", r, baud, d); end
            d = first_diff(busy_tr, exp_busy);
            total++; if (d !== -1) begin bad++; $display("FAIL rand%0d_busy: first difference at %0d", r, d); end
            total++; if (n_acc !== n) begin bad++; $display("FAIL rand%0d_accepts: got %0d expected %0d", r, n_acc, n); end
        end
    endtask

    task automatic test_reset_midframe();
        int activity;
        @(negedge clk);
        baudRate   = 20'd1;
        DATA_IN    = 8'h5A;
        data_valid = 1'b1;
        @(negedge clk);
        DATA_IN = 8'h96;
        @(negedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (15) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy: got %b expected 1", busy); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rstmid_pre_ready: got %b expected 0", ready); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (Tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b expected 1", Tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
        @(negedge clk);
        rst = 1'b0;
        activity = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (Tx !== 1'b1 || busy !== 1'b0) activity++;
        end
        total++; if (activity !== 0) begin bad++; $display("FAIL rstmid_quiet: active samples %0d expected 0", activity); end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_parity_values();
        test_back_to_back();
        test_baud();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter that sits directly upstream of the UART receiver: accepts parallel bytes over a valid/ready handshake and shifts them out on a single line in the frame format the receiver expects. It has a one-byte holding register, so the next byte can be accepted while the current frame is on the wire. Frames are start bit, 8 data bits MSB first, optional odd-parity bit, stop bit.

## Interface

Parameters:
- CLK_HZ, default 5 (50000000 on hardware): system clock frequency in Hz; sets the bit period together with baudRate.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- baudRate  input  20  bit rate; sampled only at frame start.
- DATA_IN  input  8  byte to transmit.
- data_valid  input  1  DATA_IN is valid this cycle.
- ready  output  1  holding register empty; a byte is accepted on an edge where data_valid & ready.
- Tx  output  1  serial line, idle high, registered.
- busy  output  1  high while a frame is in progress (states START through STOP).

## Operation

- Reset: Tx=1, busy=0, ready=1, holding register empty, state IDLE, counters 0.
- Handshake: on a rising edge with data_valid=1 and ready=1, DATA_IN is captured into the holding register; ready goes low the following cycle. ready returns high on the cycle after the holding byte moves into the shift register. data_valid while ready=0 is ignored; nothing is dropped silently inside the block.
- Bit period P = (CLK_HZ / baudRate) + 1 clocks (integer division), matching the receiver's sampling counter. baudRate=0 is treated as 1. baudRate is latched when the frame starts; changes mid-frame have no effect.
- State machine, one bit period per state except DATA (8 periods):
  - IDLE: Tx=1. If the holding register is full, load shift register, latch P, clear the holding register, go to START.
  - START: Tx=0.
  - DATA: Tx = shift[7]; shift left each period; bit counter 7 down to 0.
  - PARITY (only with TX_PARITY_EN): Tx = ~^byte (odd parity: ones in data+parity is odd).
  - STOP: Tx=1. At period end, if the holding register is full, go straight to START (load as in IDLE, no idle gap); otherwise go to IDLE.
- Bit counter and period counter are 4-bit and 20-bit; the period counter runs 0..P-1 and wraps to 0 on each state advance.
- Simultaneous accept and load: a byte may be accepted on the same edge that the previous holding byte is loaded only if ready was high on that edge; ready is never combinationally dependent on data_valid.
- Reset mid-frame aborts the frame: Tx=1 from the next edge; holding byte discarded.

## Timing

- Accept at edge N (IDLE, holding empty): holding full after N; START entered and Tx=0 after edge N+1; busy=1 from the same edge.
- Each line bit holds for exactly P clocks. Frame = 11·P clocks with parity, 10·P without.
- Back-to-back: stop bit of frame k is followed immediately by start bit of frame k+1 when a byte is waiting.
- busy falls on the edge that enters IDLE.

## Configuration

- TX_PARITY_EN defined: PARITY state present; 11-bit frame compatible with the receiver's odd-parity check.
- TX_PARITY_EN undefined: PARITY state removed; STOP follows the last data bit; 10-bit frame.

## Test plan

- Reset: assert rst for 2 cycles mid-frame -> Tx=1, busy=0, ready=1 on the next edge; no further line transitions.
- CLK_HZ=5, baudRate=1 (P=6), parity on, send 8'hA5 -> Tx sequence 0,1,0,1,0,0,1,0,1,1,1, each held 6 clocks; busy high for 66 clocks.
- Parity values: 8'h00 -> parity bit 1; 8'hFF -> 1; 8'h01 -> 0; loop Tx into the receiver -> DATA_OUT equals sent byte.
- Back-to-back: offer 8'h3C then 8'hC3 with data_valid held high -> second byte accepted while first is shifting, ready low until first frame's load, no idle gap between frames (22·P clocks total).
- baudRate=0 and baudRate change mid-frame -> P=6 (as baudRate=1); changed rate applies only from the next frame.
- TX_PARITY_EN undefined, send 8'hA5 at P=6 -> 10-bit frame 0,1,0,1,0,0,1,0,1,1, 60 clocks.
